// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - RESET_PC_DEF / NOP_WORD_DEF : default parameter values for fetch_stage
//   - fetch_state_e               : fetch FSM encoding (idle / fetch / hold)
//   - redir_sel_e                 : which redirect source won arbitration
//   - redir_select()              : priority encoder jr > jump > branch
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    RedirNone   = 2'd0,
    RedirBranch = 2'd1,
    RedirJump   = 2'd2,
    RedirJr     = 2'd3
  } redir_sel_e;

  // Only one source is legal at a time; priority keeps overlap deterministic.
  function automatic redir_sel_e redir_select(input logic jr, input logic jump,
                                              input logic branch);
    redir_sel_e sel;
    if (jr) begin
      sel = RedirJr;
    end else if (jump) begin
      sel = RedirJump;
    end else if (branch) begin
      sel = RedirBranch;
    end else begin
      sel = RedirNone;
    end
    return sel;
  endfunction

endpackage

// File: rtl/adder_32.sv
// Plain N-bit modulo adder.
//   i_a, i_b : operands
//   o_sum    : (i_a + i_b) mod 2^N
module adder_32 #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/fetch_redirect_latch.sv
// Redirect arbitration, pending-redirect register and next-PC mux.
//   clk, rst_n            : clock, synchronous active-low reset
//   i_complete            : the instruction in fetch is handed to decode this cycle
//   i_branch/_target      : taken branch and its destination
//   i_jump/_target        : direct jump and its destination
//   i_jr/_target          : register jump and its destination
//   i_pc, i_pc_plus4      : current PC and its sequential successor
//   o_next_pc             : PC value for the next cycle (word aligned)
module fetch_redirect_latch
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_complete,
  input  logic        i_branch,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_next_pc
);

  redir_sel_e  w_sel;
  logic        w_redirect;
  logic [31:0] w_sel_target;
  logic [31:0] w_raw_next;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  assign w_sel      = redir_select(i_jr, i_jump, i_branch);
  assign w_redirect = (w_sel != RedirNone);

  always_comb begin
    w_sel_target = i_pc_plus4;
    unique case (w_sel)
      RedirJr:     w_sel_target = i_jr_target;
      RedirJump:   w_sel_target = i_jump_target;
      RedirBranch: w_sel_target = i_branch_target;
      default:     w_sel_target = i_pc_plus4;
    endcase
  end

  // A redirect that arrives while the delay-slot instruction is still waiting
  // is parked here; the newest one wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h0;
    end else if (i_complete) begin
      r_pend_valid  <= 1'b0;
    end else if (w_redirect) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= w_sel_target;
    end
  end

  always_comb begin
    w_raw_next = i_pc;
    if (i_complete) begin
      if (w_redirect) begin
        w_raw_next = w_sel_target;
      end else if (r_pend_valid) begin
        w_raw_next = r_pend_target;
      end else begin
        w_raw_next = i_pc_plus4;
      end
    end
  end

  assign o_next_pc = {w_raw_next[31:2], 2'b00};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the decode input register.
//   clk, rst_n             : clock, synchronous active-low reset
//   stall                  : decode refuses a new instruction this cycle
//   branch/jump/jr(+target): redirects resolved in decode (one delay slot)
//   imem_req, imem_addr    : fetch request and address (= pc)
//   imem_ready, imem_rdata : fetched word valid for imem_addr this cycle
//   instruction            : word presented to decode (NOP_WORD on bubble)
//   delay, delay2          : pc+4 / pc+8 of the presented instruction
//   fetch_valid            : presented instruction is a real fetch
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] delay,
  output logic [31:0] delay2,
  output logic        fetch_valid
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_hold_word;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_pc_plus8;
  logic [31:0]  w_next_pc;
  logic         w_complete;
  logic         w_capture;

  adder_32 #(.N(32)) u_add4 (
    .i_a   (r_pc),
    .i_b   (32'd4),
    .o_sum (w_pc_plus4)
  );

  adder_32 #(.N(32)) u_add8 (
    .i_a   (r_pc),
    .i_b   (32'd8),
    .o_sum (w_pc_plus8)
  );

  fetch_redirect_latch u_redirect (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_complete      (w_complete),
    .i_branch        (branch),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_jr            (jr),
    .i_jr_target     (jr_target),
    .i_pc            (r_pc),
    .i_pc_plus4      (w_pc_plus4),
    .o_next_pc       (w_next_pc)
  );

  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    w_capture    = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = r_pc;
    instruction  = NOP_WORD;
    delay        = 32'h0;
    delay2       = 32'h0;
    fetch_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_state_next = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        delay    = w_pc_plus4;
        delay2   = w_pc_plus8;
        if (imem_ready) begin
          instruction = imem_rdata;
          fetch_valid = 1'b1;
          if (stall) begin
            w_capture    = 1'b1;
            w_state_next = StHold;
          end else begin
            w_complete = 1'b1;
          end
        end
      end
      StHold: begin
        instruction = r_hold_word;
        fetch_valid = 1'b1;
        delay       = w_pc_plus4;
        delay2      = w_pc_plus8;
        if (!stall) begin
          w_complete   = 1'b1;
          w_state_next = StFetch;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // pc stays put while holding, so the hold buffer only needs the word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_hold_word <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_next_pc;
      if (w_capture) begin
        r_hold_word <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic        jm;
    logic        jr;
    logic        rdy;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] rt;
    logic        ovr_en;
    logic [31:0] ovr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_idle;
    logic [31:0] e_instr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, jump, jr, imem_ready;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, imem_rdata, instruction, delay, delay2;
  logic        ovr_en;
  logic [31:0] ovr_word;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rdata = ovr_en ? ovr_word : mem_word(imem_addr);

  fetch_stage #(
    .RESET_PC (32'h0000_0100),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .delay         (delay),
    .delay2        (delay2),
    .fetch_valid   (fetch_valid)
  );

  function automatic vec_t fv(input logic st, input logic br, input logic jm, input logic jrr,
                              input logic rdy, input logic [31:0] bt, input logic [31:0] jt,
                              input logic [31:0] rt, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid);
    vec_t v;
    v.rst_n   = 1'b1;
    v.stall   = st;
    v.br      = br;
    v.jm      = jm;
    v.jr      = jrr;
    v.rdy     = rdy;
    v.bt      = bt;
    v.jt      = jt;
    v.rt      = rt;
    v.ovr_en  = 1'b0;
    v.ovr     = 32'h0;
    v.e_req   = e_req;
    v.e_addr  = e_addr;
    v.e_valid = e_valid;
    v.e_idle  = !e_req && !e_valid;
    v.e_instr = e_valid ? mem_word(e_addr) : 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL c%0d %s: got %h, expected %h", cyc_n, name, got, exp);
    end
  endtask

  task automatic cyc(input vec_t v);
    logic [31:0] e_d, e_d2;
    rst_n         = v.rst_n;
    stall         = v.stall;
    branch        = v.br;
    jump          = v.jm;
    jr            = v.jr;
    imem_ready    = v.rdy;
    branch_target = v.bt;
    jump_target   = v.jt;
    jr_target     = v.rt;
    ovr_en        = v.ovr_en;
    ovr_word      = v.ovr;
    e_d  = v.e_idle ? 32'h0 : v.e_addr + 32'd4;
    e_d2 = v.e_idle ? 32'h0 : v.e_addr + 32'd8;
    @(negedge clk);
    chk("imem_req", {31'h0, imem_req}, {31'h0, v.e_req});
    chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, v.e_valid});
    chk("instruction", instruction, v.e_instr);
    if (v.e_req) chk("imem_addr", imem_addr, v.e_addr);
    if (v.e_valid || v.e_idle) begin
      chk("delay", delay, e_d);
      chk("delay2", delay2, e_d2);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  vec_t tbl [0:10];
  vec_t v;

  initial begin
    // Reset, straight-line fetch, branch/jump delay slots, wrap, priority.
    tbl[0]  = fv(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0);
    tbl[1]  = fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h100, 1);
    tbl[2]  = fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h104, 1);
    tbl[3]  = fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h108, 1);
    tbl[4]  = fv(0, 1, 0, 0, 1, 32'h400, 0, 0, 1, 32'h10C, 1);
    tbl[5]  = fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h400, 1);
    tbl[6]  = fv(0, 1, 1, 1, 1, 32'h600, 32'h700, 32'h800, 1, 32'h404, 1);
    tbl[7]  = fv(0, 0, 1, 0, 1, 0, 32'hFFFF_FFFC, 0, 1, 32'h800, 1);
    tbl[8]  = fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    tbl[9]  = fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 1);
    tbl[10] = fv(0, 1, 0, 1, 1, 32'h900, 0, 32'h203, 1, 32'h4, 1);

    rst_n = 1'b0; stall = 0; branch = 0; jump = 0; jr = 0; imem_ready = 0;
    branch_target = 0; jump_target = 0; jr_target = 0; ovr_en = 0; ovr_word = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i <= 10; i++) cyc(tbl[i]);

    // Three bubbles at 0x200 (jr target 0x203 aligned), then the word.
    for (int i = 0; i < 3; i++) cyc(fv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0));
    cyc(fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h200, 1));

    // Branch arrives while the delay slot is still waiting on imem.
    cyc(fv(0, 1, 0, 0, 0, 32'h400, 0, 0, 1, 32'h204, 0));
    cyc(fv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h204, 0));
    cyc(fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h204, 1));
    cyc(fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h400, 1));
    cyc(fv(0, 0, 1, 0, 1, 0, 32'h300, 0, 1, 32'h404, 1));

    // Stall for two cycles on 0xDEADBEEF at 0x300.
    v = fv(1, 0, 0, 0, 1, 0, 0, 0, 1, 32'h300, 1);
    v.ovr_en = 1'b1; v.ovr = 32'hDEAD_BEEF; v.e_instr = 32'hDEAD_BEEF;
    cyc(v);
    v = fv(1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h300, 1);
    v.e_instr = 32'hDEAD_BEEF;
    cyc(v);
    v = fv(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h300, 1);
    v.e_instr = 32'hDEAD_BEEF;
    cyc(v);
    cyc(fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h304, 1));

    // Stall during a bubble only holds pc.
    cyc(fv(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h308, 0));
    cyc(fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h308, 1));

    // Reset with a request outstanding.
    v = fv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h30C, 0);
    v.rst_n = 1'b0;
    cyc(v);
    cyc(fv(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0));
    cyc(fv(0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h100, 1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
